// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues req/ack fetches to a
// variable-latency instruction memory and buffers {pc+4, instr} pairs in a
// small FIFO whose head is presented to decode.
module if_fetch_stage #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        valid
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DROP
  } state_t;

  state_t        r_state;
  logic          r_req;
  logic [31:0]   r_imem_addr;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_fifo_pc    [DEPTH];
  logic [31:0]   r_fifo_instr [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic          w_valid;
  logic          w_pop;
  logic          w_push;
  logic          w_room;
  logic [CW-1:0] w_count_nxt;
  logic [31:0]   w_baddr;
  logic [31:0]   w_next_addr;
  logic          w_unused;

  assign w_valid     = (r_count != '0);
  assign w_pop       = w_valid & ~freeze & ~branch_taken;
  assign w_push      = (r_state == S_BUSY) & imem_ack & ~branch_taken;
  assign w_baddr     = {branch_addr[31:2], 2'b00};
  assign w_next_addr = r_imem_addr + 32'd4;
  assign w_unused    = ^branch_addr[1:0];

  // Occupancy after this cycle's flush/push/pop; room is judged on this value
  always_comb begin
    w_count_nxt = r_count;
    if (branch_taken) begin
      w_count_nxt = '0;
    end else begin
      w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  assign w_room = (w_count_nxt < CW'(DEPTH));

  // Instruction buffer: flushed by a taken branch, otherwise push/pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_fifo_pc[i]    <= '0;
        r_fifo_instr[i] <= '0;
      end
    end else begin
      r_count <= w_count_nxt;
      if (branch_taken) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_push) begin
          r_fifo_pc[r_wr_ptr]    <= w_next_addr;
          r_fifo_instr[r_wr_ptr] <= imem_rdata;
          r_wr_ptr               <= r_wr_ptr + AW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
      end
    end
  end

  // Fetch FSM: request address is only loaded when a new request starts,
  // so it stays stable for the whole req/ack handshake (including DROP)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_req       <= 1'b0;
      r_imem_addr <= RESET_PC;
      r_fetch_pc  <= RESET_PC;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (branch_taken) begin
            r_fetch_pc <= w_baddr;
          end else if (w_room) begin
            r_imem_addr <= r_fetch_pc;
            r_state     <= S_BUSY;
            r_req       <= 1'b1;
          end
        end
        S_BUSY: begin
          if (branch_taken) begin
            r_fetch_pc <= w_baddr;
            if (imem_ack) begin
              r_state <= S_IDLE;
              r_req   <= 1'b0;
            end else begin
              r_state <= S_DROP;
            end
          end else if (imem_ack) begin
            r_fetch_pc <= w_next_addr;
            if (w_room) begin
              r_imem_addr <= w_next_addr;
            end else begin
              r_state <= S_IDLE;
              r_req   <= 1'b0;
            end
          end
        end
        S_DROP: begin
          if (branch_taken) begin
            r_fetch_pc <= w_baddr;
          end
          if (imem_ack) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req  = r_req;
  assign imem_addr = r_imem_addr;
  assign valid     = w_valid;
  assign pc        = w_valid ? r_fifo_pc[r_rd_ptr]    : '0;
  assign instr     = w_valid ? r_fifo_instr[r_rd_ptr] : '0;

  a_no_push_when_full: assert property (
    @(posedge clk) disable iff (!rst) !(w_push && (r_count == CW'(DEPTH)))
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: a stimulus process drives memory responses,
// freeze and branches and pushes the architecturally expected instruction
// stream into a scoreboard; a monitor pops it whenever decode consumes.
module tb_if_fetch_stage;

  localparam int unsigned TB_DEPTH    = 2;
  localparam logic [31:0] TB_RESET_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        valid;

  always #5 clk = ~clk;

  if_fetch_stage #(
    .DEPTH    (TB_DEPTH),
    .RESET_PC (TB_RESET_PC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .pc           (pc),
    .instr        (instr),
    .valid        (valid)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t      sb_q[$];
  logic [31:0] gen_addr;
  int          n_checks   = 0;
  int          n_errors   = 0;
  int          n_consumed = 0;

  // stimulus knobs
  bit          d_rst = 1'b0;
  bit          d_freeze = 1'b0;
  bit          d_branch = 1'b0;
  logic [31:0] d_baddr = '0;
  bit          d_force_ack = 1'b0;
  bit          rand_mode = 1'b0;
  int unsigned ws_min = 0;
  int unsigned ws_max = 0;
  int          wleft = -1;
  bit          mem_new = 1'b0;
  bit          bfa_armed = 1'b0;
  bit          bfa_hit = 1'b0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'hA5A5_A5A5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Program flow restarts at a redirect target and proceeds word by word
  task automatic sb_flush(input logic [31:0] start);
    sb_q.delete();
    gen_addr = {start[31:2], 2'b00};
  endtask

  task automatic sb_refill();
    while (sb_q.size() < 8) begin
      sb_q.push_back({gen_addr + 32'd4, mem_data(gen_addr)});
      gen_addr = gen_addr + 32'd4;
    end
  endtask

  // One clock cycle of stimulus, applied just after the falling edge
  task automatic cycle();
    @(negedge clk);
    rst        = d_rst;
    mem_new    = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    if (!rst) begin
      wleft = -1;
    end else if (d_force_ack) begin
      imem_ack    = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
      d_force_ack = 1'b0;
    end else if (imem_req) begin
      if (wleft < 0) begin
        wleft   = int'($urandom_range(ws_max, ws_min));
        mem_new = 1'b1;
      end
      if (wleft == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_data(imem_addr);
        wleft      = -1;
      end else begin
        wleft--;
      end
    end else begin
      wleft = -1;
    end
    if (rand_mode) begin
      freeze       = ($urandom_range(99) < 30);
      branch_taken = ($urandom_range(99) < 4);
      branch_addr  = ($urandom_range(1) == 1) ? $urandom
                                              : (32'hFFFF_FFE0 | 32'($urandom_range(31)));
    end else begin
      freeze       = d_freeze;
      branch_taken = d_branch;
      branch_addr  = d_baddr;
    end
    if (bfa_armed && imem_ack) begin
      freeze       = 1'b1;
      branch_taken = 1'b1;
      branch_addr  = 32'h0000_0302;
      bfa_armed    = 1'b0;
      bfa_hit      = 1'b1;
    end
    if (!rst) begin
      freeze       = 1'b0;
      branch_taken = 1'b0;
    end
    if (branch_taken) sb_flush(branch_addr);
    sb_refill();
  endtask

  task automatic cyc1();
    cycle();
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, {31'b0, valid}, 32'h0);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_instr"}, instr, 32'h0);
    chk({tag, "_req"}, {31'b0, imem_req}, 32'h0);
    chk({tag, "_addr"}, imem_addr, TB_RESET_PC);
  endtask

  // Monitor: checks consumed entries against the scoreboard and the
  // request protocol, independently of the stimulus process
  entry_t      mon_e;
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic [31:0] prev_addr = '0;

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        prev_req = 1'b0;
      end else begin
        if (imem_req) chk("addr_align", {30'b0, imem_addr[1:0]}, 32'h0);
        if (prev_req && !prev_ack && imem_req) chk("addr_stable", imem_addr, prev_addr);
        if (!valid) begin
          chk("bubble_pc", pc, 32'h0);
          chk("bubble_instr", instr, 32'h0);
        end else if (!freeze && !branch_taken) begin
          if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_empty: got pc %08h expected no consume at t=%0t", pc, $time);
          end else begin
            mon_e = sb_q.pop_front();
            chk("sb_pc", pc, mon_e.pc);
            chk("sb_instr", instr, mon_e.instr);
            n_consumed++;
          end
        end
        prev_req  = imem_req;
        prev_ack  = imem_ack;
        prev_addr = imem_addr;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;
    sb_flush(TB_RESET_PC);

    // reset state
    repeat (3) cycle();
    #1;
    chk_reset_vals("rst");

    // straight-line fetch with zero-wait memory, wrapping past 2^32
    d_rst = 1'b1;
    cyc1();
    cyc1();
    chk("n1_req", {31'b0, imem_req}, 32'h1);
    chk("n1_addr", imem_addr, 32'hFFFF_FFF8);
    chk("n1_valid", {31'b0, valid}, 32'h0);
    cyc1();
    chk("n2_valid", {31'b0, valid}, 32'h1);
    chk("n2_pc", pc, 32'hFFFF_FFFC);
    chk("n2_instr", instr, mem_data(32'hFFFF_FFF8));
    chk("n2_addr", imem_addr, 32'hFFFF_FFFC);
    cyc1();
    chk("n3_pc", pc, 32'h0);
    chk("n3_instr", instr, mem_data(32'hFFFF_FFFC));
    chk("n3_addr", imem_addr, 32'h0);
    cyc1();
    chk("n4_pc", pc, 32'h4);
    chk("n4_addr", imem_addr, 32'h4);

    // freeze: head held, FIFO fills, request drops
    d_freeze = 1'b1;
    cyc1();
    chk("frz1_pc", pc, 32'h8);
    cyc1();
    chk("frz2_pc", pc, 32'h8);
    chk("frz2_req", {31'b0, imem_req}, 32'h0);
    cyc1();
    chk("frz3_pc", pc, 32'h8);
    chk("frz3_instr", instr, mem_data(32'h4));
    chk("frz3_req", {31'b0, imem_req}, 32'h0);
    d_freeze = 1'b0;
    cyc1();
    chk("drain_pc", pc, 32'h8);
    cyc1();
    chk("drain2_pc", pc, 32'hC);
    chk("drain2_addr", imem_addr, 32'hC);
    cyc1();
    chk("drain3_pc", pc, 32'h10);

    // branch with idle memory (issued while frozen, low bits ignored)
    d_freeze = 1'b1;
    cyc1();
    chk("pre_br_pc", pc, 32'h14);
    d_branch = 1'b1;
    d_baddr  = 32'h0000_0103;
    cyc1();
    chk("br_req_idle", {31'b0, imem_req}, 32'h0);
    d_branch = 1'b0;
    d_freeze = 1'b0;
    cyc1();
    chk("br_t1_valid", {31'b0, valid}, 32'h0);
    chk("br_t1_req", {31'b0, imem_req}, 32'h0);
    cyc1();
    chk("br_t2_req", {31'b0, imem_req}, 32'h1);
    chk("br_t2_addr", imem_addr, 32'h100);

    // branch during a slow (3 wait state) fetch
    ws_min = 3;
    ws_max = 3;
    cyc1();
    chk("br_first_pc", pc, 32'h104);
    chk("br_first_instr", instr, mem_data(32'h100));
    d_branch = 1'b1;
    d_baddr  = 32'h0000_0200;
    cyc1();
    d_branch = 1'b0;
    cyc1();
    chk("drop_valid", {31'b0, valid}, 32'h0);
    chk("drop_req", {31'b0, imem_req}, 32'h1);
    chk("drop_addr", imem_addr, 32'h104);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc1();
      if (imem_req && imem_addr == 32'h200) begin
        found = 1'b1;
        break;
      end
    end
    chk("redirect_200", {31'b0, found}, 32'h1);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc1();
      if (valid) begin
        found = 1'b1;
        break;
      end
    end
    chk("redirect_200_valid", {31'b0, found}, 32'h1);
    chk("redirect_200_pc", pc, 32'h204);

    // simultaneous branch, freeze and ack
    ws_min    = 1;
    ws_max    = 2;
    bfa_armed = 1'b1;
    for (int i = 0; i < 30; i++) begin
      cyc1();
      if (bfa_hit) break;
    end
    chk("bfa_seen", {31'b0, bfa_hit}, 32'h1);
    cyc1();
    chk("bfa_valid", {31'b0, valid}, 32'h0);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req && imem_addr == 32'h300) begin
        found = 1'b1;
        break;
      end
      cyc1();
    end
    chk("bfa_redirect", {31'b0, found}, 32'h1);

    // async reset mid-request, then a late ack after release
    ws_min = 3;
    ws_max = 3;
    found  = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cyc1();
      if (mem_new) begin
        found = 1'b1;
        break;
      end
    end
    chk("arst_req_seen", {31'b0, found}, 32'h1);
    #2;
    d_rst = 1'b0;
    rst   = 1'b0;
    sb_flush(TB_RESET_PC);
    #1;
    chk_reset_vals("arst");
    cycle();
    cycle();
    ws_min      = 0;
    ws_max      = 0;
    d_rst       = 1'b1;
    d_force_ack = 1'b1;
    cyc1();
    chk("arst_rel_req", {31'b0, imem_req}, 32'h0);
    cyc1();
    chk("arst_rel2_req", {31'b0, imem_req}, 32'h1);
    chk("arst_rel2_addr", imem_addr, TB_RESET_PC);
    repeat (6) cycle();

    // randomized traffic
    ws_min    = 0;
    ws_max    = 3;
    rand_mode = 1'b1;
    repeat (3000) cycle();
    rand_mode = 1'b0;
    d_freeze  = 1'b0;
    d_branch  = 1'b0;
    repeat (4) cycle();
    #3;

    n_checks++;
    if (n_consumed < 300) begin
      n_errors++;
      $display("FAIL throughput: got %0d consumed expected at least 300", n_consumed);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage sitting directly upstream of the decode stage: it owns the program counter, fetches 32-bit instructions from a variable-latency instruction memory over a req/ack handshake, and buffers them in a small FIFO. It presents the oldest fetched instruction and its PC+4 to decode. It holds that output while decode asserts `freeze`, and flushes on a taken branch from execute.

## Interface
- `DEPTH`, default 2: instruction buffer entries. Power of two, ≥2.
- `RESET_PC`, default 32'h0: first fetch address after reset.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `freeze`  in  1  decode hazard stall; hold the current output entry.
- `branch_taken`  in  1  redirect request from execute.
- `branch_addr`  in  32  redirect target. Bits [1:0] are ignored (treated as 00).
- `imem_req`  out  1  fetch request. Held high until `imem_ack`.
- `imem_addr`  out  32  fetch address, word aligned. Stable while `imem_req`=1.
- `imem_ack`  in  1  one-cycle response strobe; `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  32  fetched instruction.
- `pc`  out  32  fetch address + 4 of the head entry; 0 when `valid`=0.
- `instr`  out  32  head-entry instruction; 0 when `valid`=0.
- `valid`  out  1  head entry present; decode treats `valid`=0 as a bubble.

## Operation
- Internal state:
  - `fetch_pc` (32b)
  - FIFO of {pc+4, instr}, with `count` in 0..DEPTH
  - fetch FSM with states IDLE, BUSY, DROP.
- `room` = (count after this cycle's push/pop) < DEPTH.
- Pop: `valid` & ~`freeze` & ~`branch_taken`.
- FSM transitions, evaluated in priority order:
  - **IDLE**
    - `branch_taken`: `fetch_pc`←`branch_addr`; stay IDLE; FIFO cleared.
    - else if `room`: latch `imem_addr`←`fetch_pc`; go to BUSY.
  - **BUSY** (request outstanding)
    - `branch_taken` with `imem_ack`: discard data; FIFO cleared; `fetch_pc`←`branch_addr`; go to IDLE.
    - `branch_taken` without `imem_ack`: FIFO cleared; `fetch_pc`←`branch_addr`; go to DROP.
    - `imem_ack`: push {`imem_addr`+4, `imem_rdata`}; `fetch_pc`←`imem_addr`+4.
      - If `room` (accounting for this push): `imem_addr`←`imem_addr`+4 and stay BUSY (back-to-back fetch).
      - Otherwise go to IDLE.
  - **DROP** (stale request outstanding)
    - `imem_ack`: discard data; go to IDLE.
    - `branch_taken` in DROP: update `fetch_pc` only; stay in DROP.
- `imem_req` = (state ≠ IDLE), registered. In DROP it stays high with the old address until ack; the address never changes mid-request.
- `branch_taken` overrides `freeze`: the FIFO flushes even while frozen.
- Push and pop in the same cycle leave `count` unchanged.
- Push never occurs while `count`=DEPTH. This is guaranteed by the `room` check; an assertion checks it.
- Address arithmetic is modulo 2^32: `imem_addr` 32'hFFFFFFFC + 4 wraps to 0, and the pushed pc field is 0.

## Timing
- Reset (async assert) values:
  - `valid`=0, `pc`=0, `instr`=0
  - `imem_req`=0, `imem_addr`=RESET_PC, `fetch_pc`=RESET_PC
  - state IDLE, `count`=0.
- Reset asserted mid-request: the request is abandoned. After release the block starts in IDLE at RESET_PC, and any late `imem_ack` is ignored (IDLE ignores ack).
- First cycle after reset release: IDLE with room, so `imem_req` rises at the next edge with `imem_addr`=RESET_PC.
- Zero-wait memory (ack in the first req cycle): `valid` rises on the edge after the ack. Steady state is one instruction per cycle with `imem_req` continuously high.
- Fetch latency: ack in cycle t, data visible on `pc`/`instr` in cycle t+1 if the FIFO was empty.
- Branch in cycle t with no outstanding request: `valid`=0 from t+1; `imem_req` with `branch_addr` at t+2.
- Branch with a stale request outstanding: a DROP cycle is added per wait state of the old request.
- Outputs are driven directly from the FIFO head registers; there is no combinational path from `imem_rdata` to `instr`.

## Test plan
- **Reset and straight-line fetch.** Stimulus: release `rst`; memory acks every req cycle with data = address^32'hA5A5A5A5. Required response: `imem_addr` sequence 0,4,8,…; `valid` one cycle after the first ack; `pc`=4,8,12,… each cycle; `instr` matches.
- **Freeze.** Stimulus: assert `freeze` for 3 cycles while `valid`=1. Required response: `pc`/`instr` held constant; FIFO fills to DEPTH; `imem_req` drops; on release, entries drain in order with no loss or duplication.
- **Branch with idle memory.** Stimulus: `branch_taken`=1, `branch_addr`=32'h100 in cycle t. Required response: `valid`=0 at t+1; `imem_addr`=32'h100 at t+2; first valid `pc`=32'h104.
- **Branch during slow fetch.** Stimulus: memory with 3 wait states; branch to 32'h200 one cycle into the request. Required response: old request held until its ack; its data is discarded; next request uses 32'h200; no stale instruction reaches `valid`.
- **Simultaneous branch, freeze and ack.** Stimulus: all three asserted in one cycle. Required response: FIFO empty and `valid`=0 next cycle; acked data dropped; next fetch at `branch_addr`.
- **Wrap-around and async reset.** Stimulus: RESET_PC=32'hFFFFFFF8; then assert `rst` mid-request. Required response: addresses FFFFFFF8, FFFFFFFC, 0 with `pc` FFFFFFFC, 0, 4; all outputs return to reset values immediately on `rst` assertion.
